serial_tx_param: RTL and testbench
==================================

# serial_tx_param

Parametrised UART transmitter: serialises DATA_W-bit words LSB-first as start bit, data bits, optional parity bit and one or two stop bits, each lasting DIV clocks. It adds a one-entry holding buffer so a producer can queue the next word mid-frame and frames go out back-to-back with no idle gap. It sits between the host-side byte producer and the TDX pin, as the generalised next-generation transmitter for the serial path.

## Interface
- DATA_W, 8: data bits per frame, 5..16.
- DIV, 5201: clocks per bit time, ≥2. Sets baud rate.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only with parity compiled in.
- m_clock  in  1  sole clock; all state changes on its rising edge.
- p_reset  in  1  reset, asynchronous, active-high.
- datain  in  DATA_W  word to send; sampled only in the cycle launch is accepted.
- launch  in  1  request. Accepted when launch=1 and ready=1.
- ready  out  1  holding buffer empty; launch will be accepted.
- busy  out  1  a frame is on the line (FSM not IDLE).
- TDX  out  1  serial line, registered, idle high.
- complete  out  1  one-cycle pulse in the last clock of the final stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Internal registers: shift register (DATA_W), holding buffer (DATA_W) plus valid flag, bit counter cnt (width clog2(DIV)), bit index idx (width clog2(DATA_W)), stop index, parity accumulator.
- IDLE with accepted launch: datain loads directly into the shift register, bypassing the buffer. State goes to START and cnt clears.
- Non-IDLE with accepted launch: datain loads into the holding buffer and valid is set.
- Every bit state counts cnt from 0 to DIV-1. At DIV-1 the bit ends and cnt returns to 0.
- START: TDX=0. Then DATA with idx=0.
- DATA: TDX=shift[idx]. idx increments at each bit end. After idx=DATA_W-1 the next state is PARITY if compiled in, else STOP. idx never addresses beyond DATA_W-1.
- PARITY: TDX = XOR of the frame's data bits, XOR PARITY_ODD.
- STOP: TDX=1 for STOP_BITS bit times.
- End of the final stop bit:
  - complete=1 for that cycle.
  - If the buffer is valid, the buffer moves to the shift register, valid clears and state goes to START.
  - Else, if launch is accepted in this same cycle, datain loads directly and state goes to START.
  - Otherwise state goes to IDLE.
- ready = ~valid. busy = (state != IDLE).
- launch while ready=0 is ignored. The word is dropped and no state changes.
- Reset: all outputs and state take reset values immediately on p_reset, including mid-frame. The holding buffer is invalidated and the in-flight frame is abandoned with no complete pulse.

## Timing
- Reset values: TDX=1, ready=1, busy=0, complete=0. Registers cleared, state IDLE.
- TDX is registered. Launch accepted in cycle N from IDLE gives TDX=0 from cycle N+1 and busy=1 from N+1.
- Each bit occupies exactly DIV cycles on TDX.
- Frame length F = 1 + DATA_W + P + STOP_BITS bits, where P=1 with parity compiled in, else 0. A frame lasts F·DIV cycles.
- complete is asserted in cycle N+F·DIV for a frame started by launch in cycle N.
- Back-to-back frames: the next start bit begins the cycle after complete, with zero idle cycles.
- ready drops the cycle after a buffered launch. It rises the cycle after the buffer transfers into the shift register.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state exists, P=1, and PARITY_ODD selects the sense.
- SERIAL_TX_PARITY_EN undefined: no PARITY state and no parity logic, P=0, and PARITY_ODD is ignored.

## Test plan
- Reset then idle (DIV=4, DATA_W=8, no parity): TDX=1, ready=1, busy=0, complete=0 held for 100 cycles.
- Single frame 0xA5 launched at cycle 10: TDX low for cycles 11–14, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high. complete in cycle 50 (F=10). busy falls at cycle 51.
- Back-to-back: launch 0x55, then 0x0F while busy. ready goes 0 the next cycle. The second start bit begins the cycle after the first complete, with no idle gap. A third launch while ready=0 is dropped; only two completes occur.
- Parity compiled in, PARITY_ODD=0 and then 1, data 0x07: parity bit is 1 with even parity and 0 with odd. complete arrives at 11·DIV.
- STOP_BITS=2, DATA_W=5, data 0x1F: line high for 2·DIV after the last data bit. F=8, so complete arrives at cycle N+32 with DIV=4.
- p_reset asserted mid-DATA with the buffer full: TDX=1, ready=1 and busy=0 immediately. No complete pulse. The next launch produces a clean frame.

Source files
------------

// File: rtl/serial_tx_param.sv
// rtl/serial_tx_param.sv - parametrised UART transmitter with a one-word holding buffer
// Optional parity bit is compiled in with SERIAL_TX_PARITY_EN.
module serial_tx_param #(
   parameter int DATA_W     = 8,
   parameter int DIV        = 5201,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              m_clock,
   input  logic              p_reset,
   input  logic [DATA_W-1:0] datain,
   input  logic              launch,
   output logic              ready,
   output logic              busy,
   output logic              TDX,
   output logic              complete
);
   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
   logic unused_parity_odd;
   assign unused_parity_odd = (PARITY_ODD != 0);
`endif

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                stop_q, stop_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [DATA_W-1:0]   buf_q, buf_d;
   logic                valid_q, valid_d;
   logic                tdx_q, tdx_d;

   logic accept, bit_end, frame_end;
   assign accept    = launch & ~valid_q;
   assign bit_end   = (cnt_q == CNT_LAST);
   assign frame_end = (state_q == S_STOP) && bit_end && (stop_q == STOP_LAST);

   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         buf_q   <= '0;
         valid_q <= 1'b0;
         tdx_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         buf_q   <= buf_d;
         valid_q <= valid_d;
         tdx_q   <= tdx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      buf_d   = buf_q;
      valid_d = valid_q;
      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      // A launch mid-frame is buffered, except on the frame's last cycle with an empty buffer,
      // where it starts the next frame directly.
      if ((state_q != S_IDLE) && accept && !frame_end) begin
         buf_d   = datain;
         valid_d = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d = datain;
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
                  stop_d  = 1'b0;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
            end
         end
`endif
         S_STOP: begin
            if (frame_end) begin
               if (valid_q) begin
                  shift_d = buf_q;
                  valid_d = 1'b0;
                  state_d = S_START;
               end else if (accept) begin
                  shift_d = datain;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (bit_end) begin
               stop_d = stop_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The line level is computed from the next state so TDX stays registered yet aligned to it.
   always_comb begin
      tdx_d = 1'b1;
      case (state_d)
         S_START:  tdx_d = 1'b0;
         S_DATA:   tdx_d = shift_d[idx_d];
`ifdef SERIAL_TX_PARITY_EN
         S_PARITY: tdx_d = (^shift_d) ^ (PARITY_ODD != 0);
`endif
         default:  tdx_d = 1'b1;
      endcase
      complete = frame_end;
      ready    = ~valid_q;
      busy     = (state_q != S_IDLE);
   end

   assign TDX = tdx_q;

endmodule

// File: tb/tb_serial_tx_param.sv
// tb/tb_serial_tx_param.sv - bench for serial_tx_param: two configurations against a frame-position model
module tb_serial_tx_param;
   localparam int DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [1:0]       launch_v;
   logic [1:0][15:0] din_v;
   logic [1:0] ready_v, busy_v, tdx_v, comp_v;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_tx_param #(.DATA_W(8), .DIV(DIV), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
      .m_clock(clk), .p_reset(rst), .datain(din_v[0][7:0]), .launch(launch_v[0]),
      .ready(ready_v[0]), .busy(busy_v[0]), .TDX(tdx_v[0]), .complete(comp_v[0]));

   serial_tx_param #(.DATA_W(5), .DIV(DIV), .STOP_BITS(2), .PARITY_ODD(1)) u_b (
      .m_clock(clk), .p_reset(rst), .datain(din_v[1][4:0]), .launch(launch_v[1]),
      .ready(ready_v[1]), .busy(busy_v[1]), .TDX(tdx_v[1]), .complete(comp_v[1]));

   function automatic int dw(input int i);
      return (i == 0) ? 8 : 5;
   endfunction
   function automatic int flen(input int i);
      return 1 + dw(i) + PAR + ((i == 0) ? 1 : 2);
   endfunction
   function automatic logic odd(input int i);
      return (i == 1);
   endfunction
   function automatic logic [15:0] msk(input int i);
      return (16'h1 << dw(i)) - 16'h1;
   endfunction

   // Model: a frame is a position 0..F*DIV-1; the line level follows from which bit slot it falls in.
   logic        m_act[2];
   int          m_pos[2];
   logic [15:0] m_word[2];
   logic [15:0] m_bword[2];
   logic        m_bv[2];

   function automatic logic exp_tdx(input int i);
      int k;
      if (!m_act[i]) return 1'b1;
      k = m_pos[i] / DIV;
      if (k == 0) return 1'b0;
      if (k <= dw(i)) return m_word[i][k-1];
      if (PAR == 1 && k == dw(i) + 1) return (^m_word[i]) ^ odd(i);
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] <= 1'b0;
            m_bv[i]  <= 1'b0;
            m_pos[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
               if (launch_v[i] && !m_bv[i]) begin
                  m_act[i]  <= 1'b1;
                  m_pos[i]  <= 0;
                  m_word[i] <= din_v[i] & msk(i);
               end
            end else if (m_pos[i] == flen(i) * DIV - 1) begin
               m_pos[i] <= 0;
               if (m_bv[i]) begin
                  m_word[i] <= m_bword[i];
                  m_bv[i]   <= 1'b0;
               end else if (launch_v[i]) begin
                  m_word[i] <= din_v[i] & msk(i);
               end else begin
                  m_act[i] <= 1'b0;
               end
            end else begin
               m_pos[i] <= m_pos[i] + 1;
               if (launch_v[i] && !m_bv[i]) begin
                  m_bword[i] <= din_v[i] & msk(i);
                  m_bv[i]    <= 1'b1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int i = 0; i < 2; i++) begin
            chk("tdx", i, tdx_v[i], exp_tdx(i));
            chk("busy", i, busy_v[i], m_act[i]);
            chk("ready", i, ready_v[i], !m_bv[i]);
            chk("complete", i, comp_v[i], m_act[i] && (m_pos[i] == flen(i) * DIV - 1));
         end
      end
   end

   task automatic run_line(input int inst, input logic [15:0] data, input logic [15:0] line, input int nb);
      @(negedge clk);
      launch_v[inst] = 1'b1;
      din_v[inst]    = data;
      @(negedge clk);
      launch_v[inst] = 1'b0;
      for (int t = 1; t <= nb * DIV; t++) begin
         chk("line_bit", inst, tdx_v[inst], line[(t-1)/DIV]);
         chk("line_done", inst, comp_v[inst], (t == nb * DIV));
         @(negedge clk);
      end
      chk("busy_after", inst, busy_v[inst], 1'b0);
      chk("tdx_after", inst, tdx_v[inst], 1'b1);
   endtask

`ifdef SERIAL_TX_PARITY_EN
   localparam logic [15:0] A5_LINE  = 16'b0000_0_1_0_10100101_0;
   localparam logic [15:0] A07_LINE = 16'b0000_0_1_1_00000111_0;
   localparam logic [15:0] B1F_LINE = 16'b0000000_11_0_11111_0;
   localparam logic [15:0] B07_LINE = 16'b0000000_11_0_00111_0;
   localparam int NB_A = 11;
   localparam int NB_B = 9;
`else
   localparam logic [15:0] A5_LINE  = 16'b000000_1_10100101_0;
   localparam logic [15:0] A07_LINE = 16'b000000_1_00000111_0;
   localparam logic [15:0] B1F_LINE = 16'b00000000_11_11111_0;
   localparam logic [15:0] B07_LINE = 16'b00000000_11_00111_0;
   localparam int NB_A = 10;
   localparam int NB_B = 8;
`endif

   initial begin
      int ncomp;
      rst      = 1'b1;
      launch_v = 2'b00;
      din_v    = '0;
      @(negedge clk);
      chk("rst_tdx", 0, {30'd0, tdx_v}, 32'd3);
      chk("rst_ready", 0, {30'd0, ready_v}, 32'd3);
      chk("rst_busy", 0, {30'd0, busy_v}, 32'd0);
      chk("rst_complete", 0, {30'd0, comp_v}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);

      run_line(0, 16'h00A5, A5_LINE, NB_A);
      run_line(0, 16'h0007, A07_LINE, NB_A);
      run_line(1, 16'h001F, B1F_LINE, NB_B);
      run_line(1, 16'h0007, B07_LINE, NB_B);

      // back-to-back with a dropped third word
      @(negedge clk);
      launch_v[0] = 1'b1;
      din_v[0]    = 16'h0055;
      @(negedge clk);
      din_v[0] = 16'h000F;
      chk("b2b_ready_n1", 0, ready_v[0], 1'b1);
      @(negedge clk);
      din_v[0] = 16'h0033;
      chk("b2b_ready_n2", 0, ready_v[0], 1'b0);
      @(negedge clk);
      launch_v[0] = 1'b0;
      ncomp = 0;
      for (int t = 3; t <= 12 * NB_A; t++) begin
         if (comp_v[0]) ncomp++;
         if (t == 4 * NB_A) chk("b2b_first_done", 0, comp_v[0], 1'b1);
         if (t == 4 * NB_A + 1) begin
            chk("b2b_gapless_start", 0, tdx_v[0], 1'b0);
            chk("b2b_busy_held", 0, busy_v[0], 1'b1);
            chk("b2b_ready_back", 0, ready_v[0], 1'b1);
         end
         @(negedge clk);
      end
      chk("b2b_completes", 0, ncomp, 2);

      // reset mid-DATA with the buffer full
      @(negedge clk);
      launch_v[0] = 1'b1;
      din_v[0]    = 16'h00C3;
      @(negedge clk);
      din_v[0] = 16'h003C;
      @(negedge clk);
      launch_v[0] = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_rst_ready", 0, ready_v[0], 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tdx", 0, tdx_v[0], 1'b1);
      chk("mid_rst_ready", 0, ready_v[0], 1'b1);
      chk("mid_rst_busy", 0, busy_v[0], 1'b0);
      chk("mid_rst_complete", 0, comp_v[0], 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      run_line(0, 16'h00A5, A5_LINE, NB_A);

      // randomized traffic on both instances
      repeat (4000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            launch_v[i] = ($urandom_range(0, 15) == 0);
            din_v[i]    = 16'($urandom);
         end
      end
      launch_v = 2'b00;
      repeat (200) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
